// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in, serial-out transmitter for a 1-bit link whose
// receiver samples on the rising clock edge.
//
// Ports:
//   clk        rising-edge clock
//   rstn       synchronous active-low reset
//   din        parallel word, sampled only on an accepting edge
//   load_valid upstream has a word on din
//   load_ready block can accept a word this cycle
//   sout       serial data bit (flop output)
//   sout_valid sout carries a valid bit this cycle (flop output)
//   sout_last  current bit is the final bit of the word (flop output)
//   busy       a word is being shifted out
//
// A new word may be accepted on the last-bit cycle, giving a gap-free stream.
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StShift = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             accept;

  assign load_ready = (state_q == StIdle) || ((state_q == StShift) && (cnt_q == LastCnt));
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      state_d = StShift;
      shreg_d = din;
      cnt_d   = '0;
    end else if (state_q == StShift) begin
      // Zeros shift in behind the data, so the register is empty (sout=0)
      // by the time the block falls back to idle.
      if (MSB_FIRST) begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
      end else begin
        shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
      end
      if (cnt_q == LastCnt) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // Registered copy of the last-bit condition keeps sout_last glitch-free.
    last_d = (state_d == StShift) && (cnt_d == LastCnt);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
    end
  end

  assign sout       = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign sout_valid = (state_q == StShift);
  assign sout_last  = last_q;
  assign busy       = (state_q == StShift);

endmodule
